// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared state, opcode and select encodings for the multicycle MIPS control path
package mips_pkg;

    // Controller states; encodings 12-15 are unused and recover to S_FETCH.
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // Shared with the ALU control decoder.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] ALUSRCB_B       = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR    = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM     = 2'b10;
    localparam logic [1:0] ALUSRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - Moore main control FSM for the multicycle MIPS datapath
//
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   op              opcode IR[31:26], looked at only in DECODE and MEMADR
//   mem_ready       memory handshake, looked at only in FETCH, MEMRD, MEMWR
//   PCWrite .. RegDst, PCSource, ALUSrcB, ALUOp   datapath strobes/selects
//   state           current state for debug
//   illegal_op      sticky unsupported-opcode flag, cleared only by reset
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter logic [3:0] RST_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic       ALUSrcA,
    output logic       RegWrite,
    output logic       RegDst,
    output logic [1:0] PCSource,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [3:0] state,
    output logic       illegal_op
);

    state_t state_q;
    state_t state_d;
    logic   set_illegal;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= state_t'(RST_STATE);
            illegal_op <= 1'b0;
        end else begin
            state_q <= state_d;
            if (set_illegal) begin
                illegal_op <= 1'b1;
            end
        end
    end

    assign state = state_q;

    always_comb begin
        state_d     = S_FETCH;
        set_illegal = 1'b0;
        case (state_q)
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDIEX;
                    default: begin
                        state_d     = S_FETCH;
                        set_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    // Reset masks every strobe combinationally so an aborted store never writes.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IRWrite     = 1'b0;
        ALUSrcA     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        PCSource    = PCSRC_ALU;
        ALUSrcB     = ALUSRCB_B;
        ALUOp       = ALUOP_ADD;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = ALUSRCB_FOUR;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                S_DECODE: ALUSrcB = ALUSRCB_IMM_SH2;
                S_MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = ALUSRCB_IMM;
                end
                S_MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEMWB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                end
                S_MEMWR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                S_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = ALUOP_FUNCT;
                end
                S_ALUWB: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = ALUOP_SUB;
                    PCWriteCond = 1'b1;
                    PCSource    = PCSRC_ALUOUT;
                end
                S_JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = PCSRC_JUMP;
                end
                S_ADDIEX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = ALUSRCB_IMM;
                end
                S_ADDIWB: RegWrite = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - scoreboard bench for mips_multicycle_ctrl
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = 6'd0;
    logic       mem_ready = 1'b0;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
    logic       IRWrite, ALUSrcA, RegWrite, RegDst;
    logic [1:0] PCSource, ALUSrcB, ALUOp;
    logic [3:0] state;
    logic       illegal_op;

    mips_multicycle_ctrl dut (
        .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
        .RegDst(RegDst), .PCSource(PCSource), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .state(state), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    localparam int K_R = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_J = 4, K_ADDI = 5, K_ILL = 6;

    typedef struct {
        int          st;
        logic [15:0] outs;
        logic        ill;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    bit   ill_model = 1'b0;

    wire [15:0] act_outs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
                            IRWrite, ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALUOp};

    // Output table written straight from the state descriptions.
    function automatic logic [15:0] exp_out(int st, logic mr, logic rst);
        logic pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd;
        logic [1:0] pcs, asb, aop;
        {pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd} = '0;
        pcs = 2'b00; asb = 2'b00; aop = 2'b00;
        if (!rst) begin
            case (st)
                0:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
                1:  asb = 2'b11;
                2:  begin asa = 1; asb = 2'b10; end
                3:  begin mrd = 1; iord = 1; end
                4:  begin rw = 1; m2r = 1; end
                5:  begin mwr = 1; iord = 1; end
                6:  begin asa = 1; aop = 2'b10; end
                7:  begin rw = 1; rd = 1; end
                8:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
                9:  begin pcw = 1; pcs = 2'b10; end
                10: begin asa = 1; asb = 2'b10; end
                11: rw = 1;
                default: ;
            endcase
        end
        return {pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd, pcs, asb, aop};
    endfunction

    function automatic logic [5:0] opcode_of(int k);
        logic [5:0] o;
        case (k)
            K_R:    o = 6'b000000;
            K_LW:   o = 6'b100011;
            K_SW:   o = 6'b101011;
            K_BEQ:  o = 6'b000100;
            K_J:    o = 6'b000010;
            K_ADDI: o = 6'b001000;
            default: begin
                do o = 6'($urandom);
                while (o == 6'b000000 || o == 6'b100011 || o == 6'b101011 ||
                       o == 6'b000100 || o == 6'b000010 || o == 6'b001000);
            end
        endcase
        return o;
    endfunction

    function automatic logic [5:0] rop();
        return 6'($urandom);
    endfunction

    function automatic logic rmr();
        return 1'($urandom);
    endfunction

    // One clock cycle: drive inputs, record what the DUT must show in this cycle.
    task automatic cycle(input int st, input logic [5:0] o, input logic mr, input logic rst);
        exp_t e;
        op = o;
        mem_ready = mr;
        reset = rst;
        e.st = st;
        e.outs = exp_out(st, mr, rst);
        e.ill = ill_model;
        e.cyc = cyc;
        q.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        if (rst) ill_model = 1'b0;
    endtask

    // One instruction as a list of states; fs/ms are stall cycles in FETCH and the memory state.
    task automatic do_instr(input int k, input int fs, input int ms);
        logic [5:0] opc;
        opc = opcode_of(k);
        for (int i = 0; i < fs; i++) cycle(0, rop(), 1'b0, 1'b0);
        cycle(0, rop(), 1'b1, 1'b0);
        cycle(1, opc, rmr(), 1'b0);
        case (k)
            K_R:    begin cycle(6, rop(), rmr(), 0); cycle(7, rop(), rmr(), 0); end
            K_LW: begin
                cycle(2, opc, rmr(), 0);
                for (int i = 0; i < ms; i++) cycle(3, rop(), 1'b0, 0);
                cycle(3, rop(), 1'b1, 0);
                cycle(4, rop(), rmr(), 0);
            end
            K_SW: begin
                cycle(2, opc, rmr(), 0);
                for (int i = 0; i < ms; i++) cycle(5, rop(), 1'b0, 0);
                cycle(5, rop(), 1'b1, 0);
            end
            K_BEQ:  cycle(8, rop(), rmr(), 0);
            K_J:    cycle(9, rop(), rmr(), 0);
            K_ADDI: begin cycle(10, rop(), rmr(), 0); cycle(11, rop(), rmr(), 0); end
            default: ill_model = 1'b1;
        endcase
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks += 3;
            if (state !== 4'(e.st)) begin
                errors++;
                $display("FAIL state cyc=%0d actual=%0d expected=%0d", e.cyc, state, e.st);
            end
            if (act_outs !== e.outs) begin
                errors++;
                $display("FAIL outputs cyc=%0d state=%0d actual=%h expected=%h",
                         e.cyc, e.st, act_outs, e.outs);
            end
            if (illegal_op !== e.ill) begin
                errors++;
                $display("FAIL illegal_op cyc=%0d actual=%b expected=%b", e.cyc, illegal_op, e.ill);
            end
        end
    end

    initial begin
        @(posedge clk);
        #1;
        cycle(0, rop(), rmr(), 1'b1);
        cycle(0, rop(), rmr(), 1'b1);

        do_instr(K_R, 0, 0);
        do_instr(K_LW, 2, 3);
        do_instr(K_SW, 0, 0);
        do_instr(K_BEQ, 0, 0);
        do_instr(K_J, 0, 0);
        do_instr(K_ADDI, 0, 0);
        cycle(0, rop(), 1'b1, 1'b0);
        cycle(1, 6'b111111, rmr(), 1'b0);
        ill_model = 1'b1;
        do_instr(K_R, 0, 0);
        do_instr(K_LW, 1, 0);

        // Store aborted by reset while stalled in MEMWR.
        cycle(0, rop(), 1'b1, 0);
        cycle(1, 6'b101011, rmr(), 0);
        cycle(2, 6'b101011, rmr(), 0);
        cycle(5, rop(), 1'b0, 0);
        cycle(5, rop(), 1'b0, 1'b1);
        cycle(0, rop(), rmr(), 1'b1);
        do_instr(K_R, 0, 0);

        for (int n = 0; n < 400; n++) begin
            int k;
            k = int'($urandom_range(0, 12));
            if (k > 6) k = k - 6;
            if (($urandom % 40) == 0) begin
                cycle(0, rop(), rmr(), 1'b1);
            end else begin
                do_instr(k, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            end
        end

        @(negedge clk);
        @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
